arm_multicycle_ctrl: RTL and testbench
======================================

// Module: arm_multicycle_ctrl
// PURPOSE
//  Control unit for the multicycle ARM core. It replaces the single-cycle decode/condlogic pair.
//  A Moore FSM sequences each instruction over 3-5 cycles so that one memory and one ALU can be shared.
//  Versus single-cycle: 3-bit ALU control (ADD/SUB/AND/ORR/EOR), CMP/TST/CMN with no writeback, LDRB/STRB.
//  Condition flags and registered CondEx live here. Drives the multicycle datapath muxes and enables.
// PARAMETERS
//  ALUCTRL_W   3  width of ALUControl; must be >=3
//  EN_NOWB     1  1: CMP/TST/CMN (Funct[4:1]=1010/1000/1011, S=1) suppress RegWrite
//  EN_BYTE     1  1: ByteEn follows Instr[22] on LDR/STR; 0: ByteEn tied 0
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low; clears FSM, Flags, CondEx
//  Instr       in   20  Instr[31:12] from instruction register
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  PCWrite     out  1   PC register enable
//  AdrSrc      out  1   0:PC 1:ALUOut as memory address
//  MemWrite    out  1   data memory write enable
//  IRWrite     out  1   instruction register enable
//  RegWrite    out  1   register file write enable
//  ResultSrc   out  2   00:ALUOut 01:Data 10:ALUResult
//  ALUSrcA     out  1   0:Rn 1:PC
//  ALUSrcB     out  2   00:Rm 01:ExtImm 10:const 4
//  ImmSrc      out  2   00:imm8 01:imm12 10:branch imm24<<2
//  RegSrc      out  2   as single-cycle: [0] RA1=R15, [1] RA2=Rd
//  ALUControl  out  ALUCTRL_W  000 ADD 001 SUB 010 AND 011 ORR 100 EOR
//  ByteEn      out  1   byte access for LDRB/STRB
// BEHAVIOUR
//  Reset (async, reset=0): state=FETCH; Flags=0; CondEx_q=0. All outputs are the combinational FETCH values.
//  States and next-state rules:
//   FETCH -> DECODE
//   DECODE -> MEMADR (Op=01), EXECUTER (Op=00, I=0), EXECUTEI (Op=00, I=1), BRANCH (Op=10)
//   DECODE -> FETCH for Op=11 or an unknown op (treated as NOP)
//   MEMADR -> MEMRD (L=1) or MEMWR (L=0); MEMRD -> MEMWB -> FETCH; MEMWR -> FETCH
//   EXECUTER/EXECUTEI -> ALUWB -> FETCH; BRANCH -> FETCH
//  Outputs per state (unlisted outputs = 0, ALUControl=ADD):
//   FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1
//   DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
//   MEMADR: ALUSrcB=01; MEMRD: AdrSrc=1; MEMWB: ResultSrc=01, RegWrite=CondEx_q
//   MEMWR: AdrSrc=1, MemWrite=CondEx_q
//   EXECUTER: ALUSrcB=00, ALU op decoded; EXECUTEI: ALUSrcB=01, ALU op decoded
//   ALUWB: RegWrite=CondEx_q & ~NoWB; PCWrite also set if Rd=15 & CondEx_q & ~NoWB
//   BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx_q
//  Combinational outputs:
//   ImmSrc and RegSrc are decoded from Op in every state, as in single-cycle.
//   ByteEn = EN_BYTE & Op=01 & Instr[22].
//  CondEx_q: latched at the end of DECODE from condcheck(Cond, Flags); Cond=1111 gives 0. Held until the next DECODE.
//  Flags: written only in the EXECUTER/EXECUTEI cycle when S=1 and CondEx_q=1.
//   N and Z always update; C and V update only for ADD/SUB/CMP/CMN.
//   New flags are visible to the next instruction's DECODE, never to the current one.
//  Unknown Funct[4:1] with Op=00: ALUControl=ADD, NoWB=1 (no state corruption).
// STRUCTURE
//  Package arm_mc_pkg: state enum (4-bit), ALU op localparams, ResultSrc/ALUSrcB encodings.
//  Sub-module: arm_condcheck (combinational, same truth table as single-cycle condcheck).
//  Flag and CondEx registers stay in the top; reuse flopenr with an inverted-reset wrapper.
// TESTING
//  1 Reset low mid-MEMRD -> next clk edge state=FETCH, Flags=0000, no RegWrite pulse.
//  2 ADD R2,R0,#5 (E2802005) -> 4 cycles: IRWrite@1, RegWrite@4 only, ALUControl=000 in EXECUTEI.
//  3 SUBS R8,R7,R2 with R7=R2 -> Z=1, C=1; following BEQ (0A000002) -> PCWrite in BRANCH.
//  4 CMP R3,#3 (E3530003) -> Flags updated, RegWrite stays 0 in ALUWB.
//  5 LDRB R1,[R0,#4] (E5D01004) -> 5 cycles, ByteEn=1, AdrSrc=1 in MEMRD, RegWrite@MEMWB.
//  6 STRNE with Z=1 (15802000) -> MemWrite never asserted, returns to FETCH after 4 cycles.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOrr = 3'b011;
    localparam logic [2:0] AluEor = 3'b100;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcbRm   = 2'b00;
    localparam logic [1:0] SrcbImm  = 2'b01;
    localparam logic [1:0] SrcbFour = 2'b10;

    localparam logic [1:0] OpDp     = 2'b00;
    localparam logic [1:0] OpMem    = 2'b01;
    localparam logic [1:0] OpBranch = 2'b10;

endpackage

// File: rtl/arm_condcheck.sv
// ARM condition-code evaluation against the stored {N,Z,C,V} flags.
module arm_condcheck
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags_i;
    assign ge = (n == v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~(c & ~z);
            4'b1010: cond_ex_o = ge;
            4'b1011: cond_ex_o = ~ge;
            4'b1100: cond_ex_o = ~z & ge;
            4'b1101: cond_ex_o = ~(~z & ge);
            4'b1110: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Moore-FSM control unit for the multicycle ARM core, holding the flags and registered CondEx.
module arm_multicycle_ctrl
    import arm_mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned EN_NOWB   = 1,
    parameter int unsigned EN_BYTE   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 ByteEn
);

    state_e     state_q, state_d;
    logic [3:0] flags_q;
    logic       condex_q, cond_ex;
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, s_bit, l_bit;
    logic [2:0] alu_op, alu_ctl;
    logic       nowb, arith, known, flags_we, alu_wb;
    logic       unused_instr;

    // Instr carries bits [31:12], so architectural bit k sits at index k-12.
    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign i_bit = Instr[13];
    assign cmd   = Instr[12:9];
    assign s_bit = Instr[8];
    assign l_bit = Instr[8];
    assign rd    = Instr[3:0];
    assign unused_instr = ^Instr[7:4];

    arm_condcheck u_condcheck (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // Unknown data-processing functions run as ADD with writeback and flags suppressed.
    always_comb begin
        alu_op = AluAdd;
        nowb   = 1'b0;
        arith  = 1'b0;
        known  = 1'b1;
        case (cmd)
            4'b0100: arith = 1'b1;
            4'b0010: begin alu_op = AluSub; arith = 1'b1; end
            4'b0000: alu_op = AluAnd;
            4'b1100: alu_op = AluOrr;
            4'b0001: alu_op = AluEor;
            4'b1010: begin alu_op = AluSub; arith = 1'b1; nowb = (EN_NOWB != 0) && s_bit; end
            4'b1000: begin alu_op = AluAnd; nowb = (EN_NOWB != 0) && s_bit; end
            4'b1011: begin arith = 1'b1; nowb = (EN_NOWB != 0) && s_bit; end
            default: begin known = 1'b0; nowb = 1'b1; end
        endcase
    end

    assign flags_we = ((state_q == StExecuteR) || (state_q == StExecuteI)) &&
                      s_bit && condex_q && known;
    assign alu_wb   = condex_q & ~nowb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFetch;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flags_we) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (arith) flags_q[1:0] <= ALUFlags[1:0];
            end
            if (state_q == StDecode) condex_q <= cond_ex;
        end
    end

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SrcbRm;
        alu_ctl   = AluAdd;
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcbFour;
                ResultSrc = ResAluResult;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcbFour;
                ResultSrc = ResAluResult;
                case (op)
                    OpMem:    state_d = StMemAdr;
                    OpDp:     state_d = i_bit ? StExecuteI : StExecuteR;
                    OpBranch: state_d = StBranch;
                    default:  state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = SrcbImm;
                state_d = l_bit ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = condex_q;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
                state_d  = StFetch;
            end
            StExecuteR: begin
                alu_ctl = alu_op;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcB = SrcbImm;
                alu_ctl = alu_op;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = alu_wb;
                PCWrite  = alu_wb && (rd == 4'hf);
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcB   = SrcbImm;
                ResultSrc = ResAluResult;
                PCWrite   = condex_q;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    assign ALUControl = ALUCTRL_W'(alu_ctl);
    assign ImmSrc     = (op == OpMem) ? 2'b01 : (op == OpBranch) ? 2'b10 : 2'b00;
    assign RegSrc     = {op == OpMem, op == OpBranch};
    assign ByteEn     = (EN_BYTE != 0) && (op == OpMem) && Instr[10];

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench: directed instructions plus random ones against a per-instruction cycle model.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ByteEn;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_flags;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .ByteEn     (ByteEn)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegSrc, ALUControl, ByteEn};

    // Expected output word; ImmSrc/RegSrc/ByteEn derive from the instruction class alone.
    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] res,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [31:0] ins);
        logic [1:0] op;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic       be;
        op   = ins[27:26];
        imm  = 2'b00;
        rsrc = 2'b00;
        be   = 1'b0;
        if (op == 2'b01) begin imm = 2'b01; rsrc = 2'b10; be = ins[22]; end
        if (op == 2'b10) begin imm = 2'b10; rsrc = 2'b01; end
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, rsrc, alu, be};
    endfunction

    // EQ,CS,MI,VS,HI,GE,GT form the base; odd codes invert; 1110 always, 1111 never.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH; af<0 drives random ALU flags each cycle.
    // abort_at>=0 pulls reset low during that cycle index and checks the async return to FETCH.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int af,
                             input int abort_at);
        logic [17:0] q[$];
        logic [1:0]  op;
        logic [3:0]  cmd;
        logic        ok, s, nowb, arith, wb;
        logic [2:0]  aop;
        int          ex_idx;
        op     = ins[27:26];
        cmd    = ins[24:21];
        s      = ins[20];
        ok     = cond_holds(ins[31:28], m_flags);
        ex_idx = -1;
        aop    = 3'd0;
        arith  = 1'b0;
        nowb   = 1'b0;
        case (cmd)
            4'b0100: arith = 1'b1;
            4'b0010: begin aop = 3'd1; arith = 1'b1; end
            4'b0000: aop = 3'd2;
            4'b1100: aop = 3'd3;
            4'b0001: aop = 3'd4;
            4'b1010: begin aop = 3'd1; arith = 1'b1; nowb = s; end
            4'b1000: begin aop = 3'd2; nowb = s; end
            4'b1011: begin arith = 1'b1; nowb = s; end
            default: nowb = 1'b1;
        endcase
        q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'd0, ins));
        q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'd0, ins));
        if (op == 2'b00) begin
            wb = ok && !nowb;
            ex_idx = 2;
            q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, ins[25] ? 2'b01 : 2'b00, aop, ins));
            q.push_back(mk(wb && (ins[15:12] == 4'hf), 0, 0, 0, wb, 2'b00, 0, 2'b00, 3'd0,
                           ins));
        end else if (op == 2'b01) begin
            q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'd0, ins));
            if (ins[20]) begin
                q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, ins));
                q.push_back(mk(0, 0, 0, 0, ok, 2'b01, 0, 2'b00, 3'd0, ins));
            end else begin
                q.push_back(mk(0, 1, ok, 0, 0, 2'b00, 0, 2'b00, 3'd0, ins));
            end
        end else if (op == 2'b10) begin
            q.push_back(mk(ok, 0, 0, 0, 0, 2'b10, 0, 2'b01, 3'd0, ins));
        end
        Instr = ins[31:12];
        for (int i = 0; i < q.size(); i++) begin
            ALUFlags = (af < 0) ? 4'($urandom) : 4'(af);
            #1;
            check($sformatf("%s_c%0d", tag, i), q[i]);
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check({tag, "_rst_async"}, mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'd0, ins));
                @(posedge clk);
                #1;
                check({tag, "_rst_hold"}, mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'd0, ins));
                m_flags = 4'b0000;
                reset = 1'b1;
                return;
            end
            if (i == ex_idx && s && ok && cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100,
                                                      4'b0001, 4'b1010, 4'b1000, 4'b1011})
            begin
                m_flags[3:2] = ALUFlags[3:2];
                if (arith) m_flags[1:0] = ALUFlags[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0]  dp_cmds [8];
        logic [31:0] ins;
        dp_cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b1011};
        m_flags  = 4'b0000;
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'hf;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'd0, 32'h0));
        reset = 1'b1;

        run_instr("add_imm", 32'hE2802005, -1, -1);
        run_instr("cmp_imm", 32'hE3530003, 4'b1000, -1);
        run_instr("bmi_taken", 32'h4A000002, -1, -1);
        run_instr("subs_eq", 32'hE0578002, 4'b0110, -1);
        run_instr("beq_taken", 32'h0A000002, -1, -1);
        run_instr("strne_skip", 32'h15802000, -1, -1);
        run_instr("ldrb", 32'hE5D01004, -1, -1);
        run_instr("ldr_rst", 32'hE5901004, 4'hf, 3);
        run_instr("streq_after_rst", 32'h05802000, -1, -1);
        run_instr("bcs_after_rst", 32'h2A000001, -1, -1);
        run_instr("op11_nop", 32'hEC000000, -1, -1);
        run_instr("add_pc_wb", 32'hE080F001, -1, -1);

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[27:26] = 2'($urandom_range(0, 3));
            if (ins[27:26] == 2'b00) ins[24:21] = dp_cmds[$urandom_range(0, 7)];
            run_instr($sformatf("rnd%0d", n), ins, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
